pipo_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one PIPO-style stage/output register pair between N requesters.
- Each requester presents a parallel word and holds `req`.
- The scheduler picks a winner, loads its word into the internal stage register (load phase), then transfers it to the output register (transfer phase). It presents the word downstream with a valid/ready handshake and source ID.
- Sits between parallel producers and a single parallel consumer.

---
 rtl/pipo_rr_scheduler.sv | 106 ++++++++++
 tb/tb_pipo_rr_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipo_rr_scheduler.sv
// Round-robin scheduler that shares one stage/output register pair between N requesters.
// A winner's word is loaded into stage, then transferred to pout and presented with a source ID.
module pipo_rr_scheduler #(
  parameter int N    = 4,
  parameter int W    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  din,
  output logic [N-1:0]    gnt,
  output logic [W-1:0]    pout,
  output logic [ID_W-1:0] out_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [W-1:0]    stage;
  logic [ID_W-1:0] stage_id;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] ptr_nxt;
  logic            found;
  logic            grant;

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign ptr_nxt   = (int'(winner) == N - 1) ? '0 : winner + ID_W'(1);
  assign grant     = (state == IDLE) && en && found;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Handshake: a word is accepted at a rising edge where out_valid && out_ready;
  // out_valid, pout and out_id hold until then, and out_ready is ignored otherwise.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (grant) state_d = XFER;
      XFER:    state_d = PRESENT;
      PRESENT: if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      pout      <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
      stage     <= '0;
      stage_id  <= '0;
      ptr       <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (grant) begin
            stage    <= din[int'(winner)*W +: W];
            stage_id <= winner;
            gnt      <= N'(1) << winner;
            ptr      <= ptr_nxt;
          end
        end
        XFER: begin
          pout      <= stage;
          out_id    <= stage_id;
          out_valid <= 1'b1;
        end
        PRESENT: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipo_rr_scheduler.sv
// Bench for pipo_rr_scheduler: directed cases plus randomized words against a
// transaction-level round-robin model and an expected-word queue.
module tb_pipo_rr_scheduler;
  localparam int N    = 4;
  localparam int W    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst, en, out_ready;
  logic [N-1:0]    req;
  logic [N*W-1:0]  din;
  logic [N-1:0]    gnt;
  logic [W-1:0]    pout;
  logic [ID_W-1:0] out_id;
  logic            out_valid, busy;
  logic [1:0]      dbg_state;

  pipo_rr_scheduler #(.N(N), .W(W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .din(din),
    .gnt(gnt), .pout(pout), .out_id(out_id), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: pending requests, their words, round-robin pointer
  logic [N-1:0]      pend;
  logic [W-1:0]      word [N];
  int                m_ptr;
  logic [ID_W+W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    req = pend;
    for (int i = 0; i < N; i++) din[i*W +: W] = word[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word end to end: optional en-off cycles, grant, transfer, stall, accept.
  task automatic run_word(input logic [N-1:0] add, input int stall, input int en_off,
                          input bit rst_mid);
    int w;
    logic [ID_W+W-1:0] e;
    for (int i = 0; i < N; i++)
      if (add[i] && !pend[i]) begin
        pend[i] = 1'b1;
        word[i] = W'($urandom);
      end
    if (pend == '0) begin
      w = $urandom_range(0, N-1);
      pend[w] = 1'b1;
      word[w] = W'($urandom);
    end
    drive_inputs();
    out_ready = 1'($urandom);
    en = 1'b0;
    for (int c = 0; c < en_off; c++) begin
      tick();
      check("en_off_gnt", 32'(gnt), 0);
      check("en_off_busy", 32'(busy), 0);
    end
    en = 1'b1;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    tick();
    check("grant", 32'(gnt), 32'(1) << w);
    check("grant_busy", 32'(busy), 1);
    check("grant_valid", 32'(out_valid), 0);
    exp_q.push_back({ID_W'(w), word[w]});
    m_ptr   = (w + 1) % N;
    pend[w] = 1'b0;
    word[w] = W'($urandom);
    drive_inputs();
    out_ready = (stall == 0);
    en = 1'($urandom);
    tick();
    e = exp_q.pop_front();
    check("xfer_valid", 32'(out_valid), 1);
    check("xfer_pout", 32'(pout), 32'(e[W-1:0]));
    check("xfer_id", 32'(out_id), 32'(e[ID_W+W-1:W]));
    check("xfer_gnt", 32'(gnt), 0);
    if (rst_mid) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_valid", 32'(out_valid), 0);
      check("rstmid_pout", 32'(pout), 0);
      check("rstmid_id", 32'(out_id), 0);
      check("rstmid_busy", 32'(busy), 0);
      m_ptr = 0;
      en = 1'b1;
      return;
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 32'(out_valid), 1);
      check("stall_pout", 32'(pout), 32'(e[W-1:0]));
      check("stall_id", 32'(out_id), 32'(e[ID_W+W-1:W]));
      check("stall_gnt", 32'(gnt), 0);
      check("stall_busy", 32'(busy), 1);
    end
    out_ready = 1'b1;
    tick();
    check("accept_valid", 32'(out_valid), 0);
    check("accept_busy", 32'(busy), 0);
    check("accept_gnt", 32'(gnt), 0);
    check("accept_pout_hold", 32'(pout), 32'(e[W-1:0]));
    out_ready = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; out_ready = 1'b0;
    pend = '1;
    for (int i = 0; i < N; i++) word[i] = W'(i + 1);
    m_ptr = 0;
    drive_inputs();
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_pout", 32'(pout), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // fairness: all four requesting, words 1..4, served 0,1,2,3
    for (int i = 0; i < N; i++) run_word('0, 0, 0, 1'b0);

    // single requester 2 with word 1011 under backpressure
    pend = '0;
    word[2] = 4'b1011;
    pend[2] = 1'b1;
    run_word('0, 5, 0, 1'b0);

    // ptr now 3: wrap gives 0 then 1; second one waits out en=0
    run_word(4'b0011, 0, 0, 1'b0);
    run_word('0, 0, 3, 1'b0);

    // reset while presenting, then grant search restarts at 0
    run_word(4'b0100, 0, 0, 1'b1);
    run_word(4'b1001, 0, 0, 1'b0);

    for (int t = 0; t < 300; t++)
      run_word(N'($urandom), $urandom_range(0, 4), $urandom_range(0, 2), ($urandom_range(0, 19) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
